// File: rtl/layer_serializer.sv
// layer_serializer: parallel-in / serial-out word serializer, transmitting end
// of the inter-layer serial link. Captures X0..X9 in one cycle and emits them
// one word per accepted beat (Valid & Out_ready), X0 first.
//
// Ports:
//   CLK        clock, rising edge
//   reset      synchronous, active-high reset
//   Load       capture request, honoured only while Ready=1
//   X0..X9     signed parallel input words
//   Ready      idle, will accept Load
//   Outdato    current serial word (buffer word 0)
//   Valid      Outdato holds a valid word
//   Out_ready  downstream accepts the word this cycle
//   Index      position 0..9 of the word on Outdato
//   Last       high with Valid on the word at Index 9
//
// Build option: define LAYER_SERIALIZER_RELU_EN to zero negative words at
// capture (ReLU activation). Handshake and timing are unchanged.
module layer_serializer #(
   parameter int unsigned Width = 10
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    Load,
   input  logic signed [Width-1:0] X0,
   input  logic signed [Width-1:0] X1,
   input  logic signed [Width-1:0] X2,
   input  logic signed [Width-1:0] X3,
   input  logic signed [Width-1:0] X4,
   input  logic signed [Width-1:0] X5,
   input  logic signed [Width-1:0] X6,
   input  logic signed [Width-1:0] X7,
   input  logic signed [Width-1:0] X8,
   input  logic signed [Width-1:0] X9,
   output logic                    Ready,
   output logic signed [Width-1:0] Outdato,
   output logic                    Valid,
   input  logic                    Out_ready,
   output logic [3:0]              Index,
   output logic                    Last
);

   localparam int Words = 10;

   typedef enum logic {StIdle, StShift} state_e;

   state_e                  r_state;
   state_e                  w_state_next;
   logic signed [Width-1:0] r_buf [Words];
   logic [3:0]              r_index;
   logic signed [Width-1:0] w_in  [Words];
   logic signed [Width-1:0] w_cap [Words];
   logic                    w_accept;
   logic                    w_last_beat;

   assign w_in[0] = X0;
   assign w_in[1] = X1;
   assign w_in[2] = X2;
   assign w_in[3] = X3;
   assign w_in[4] = X4;
   assign w_in[5] = X5;
   assign w_in[6] = X6;
   assign w_in[7] = X7;
   assign w_in[8] = X8;
   assign w_in[9] = X9;

   // Values written into the buffer on capture.
   always_comb begin
      for (int i = 0; i < Words; i++) begin
`ifdef LAYER_SERIALIZER_RELU_EN
         w_cap[i] = w_in[i][Width-1] ? '0 : w_in[i];
`else
         w_cap[i] = w_in[i];
`endif
      end
   end

   assign w_accept    = (r_state == StShift) && Out_ready;
   assign w_last_beat = (r_index == 4'd9);

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (Load) w_state_next = StShift;
         StShift: if (w_accept && w_last_beat) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Buffer and beat counter. Word 0 is always the word on Outdato, so the
   // buffer shifts down on every accepted beat and is zero whenever idle.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < Words; i++) r_buf[i] <= '0;
         r_index <= '0;
      end else if (r_state == StIdle) begin
         if (Load) begin
            r_buf   <= w_cap;
            r_index <= '0;
         end
      end else if (w_accept) begin
         if (w_last_beat) begin
            for (int i = 0; i < Words; i++) r_buf[i] <= '0;
            r_index <= '0;
         end else begin
            for (int i = 0; i < Words - 1; i++) r_buf[i] <= r_buf[i+1];
            r_buf[Words-1] <= '0;
            r_index        <= r_index + 4'd1;
         end
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      Ready   = (r_state == StIdle);
      Valid   = (r_state == StShift);
      Outdato = r_buf[0];
      Index   = r_index;
      Last    = (r_state == StShift) && w_last_beat;
   end

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer. Expected words are pushed to a
// queue when a frame is loaded and popped as each beat is accepted. A
// downstream shift register (Enable = Valid & Out_ready) checks loopback.
module tb_layer_serializer;

   logic              CLK;
   logic              reset;
   logic              Load;
   logic signed [9:0] xs [10];
   logic              Ready;
   logic signed [9:0] Outdato;
   logic              Valid;
   logic              Out_ready;
   logic [3:0]        Index;
   logic              Last;

   int n_cmp = 0;
   int n_err = 0;
   logic signed [9:0] q [$];
   logic signed [9:0] y [10];

   layer_serializer #(.Width(10)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .Load      (Load),
      .X0        (xs[0]),
      .X1        (xs[1]),
      .X2        (xs[2]),
      .X3        (xs[3]),
      .X4        (xs[4]),
      .X5        (xs[5]),
      .X6        (xs[6]),
      .X7        (xs[7]),
      .X8        (xs[8]),
      .X9        (xs[9]),
      .Ready     (Ready),
      .Outdato   (Outdato),
      .Valid     (Valid),
      .Out_ready (Out_ready),
      .Index     (Index),
      .Last      (Last)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Downstream serial-in register: words enter at Y9 and move toward Y0.
   always @(posedge CLK) begin
      if (Valid && Out_ready) begin
         for (int k = 0; k < 9; k++) y[k] <= y[k+1];
         y[9] <= Outdato;
      end
   end

   function automatic logic signed [9:0] model(input logic signed [9:0] x);
`ifdef LAYER_SERIALIZER_RELU_EN
      return x[9] ? 10'sd0 : x;
`else
      return x;
`endif
   endfunction

   // Pulse Load for one edge and queue the expected words.
   task automatic load_frame();
      Load = 1'b1;
      for (int i = 0; i < 10; i++) q.push_back(model(xs[i]));
      @(posedge CLK); #1;
      Load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; Load = 1'b0; Out_ready = 1'b0;
      for (int i = 0; i < 10; i++) xs[i] = '0;
      repeat (2) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      n_cmp++; if (Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", Ready); end
      n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", Valid); end
      n_cmp++; if (Outdato !== 10'sd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", Outdato); end
      n_cmp++; if (Index !== 4'd0) begin n_err++; $display("FAIL reset_index: got %0d want 0", Index); end
      n_cmp++; if (Last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", Last); end
   endtask

   task automatic test_basic();
      int beat, cyc;
      logic signed [9:0] e;
      for (int i = 0; i < 10; i++) xs[i] = 10'(i + 1);
      Out_ready = 1'b1;
      load_frame();
      beat = 0; cyc = 1;
      while (Ready !== 1'b1 && cyc < 40) begin
         @(negedge CLK);
         e = (q.size() > 0) ? q.pop_front() : 10'sd0;
         n_cmp++;
         if (Valid !== 1'b1 || Outdato !== e || Index !== 4'(beat) || Last !== (beat == 9)) begin
            n_err++;
            $display("FAIL basic beat %0d: got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                     beat, Valid, Outdato, Index, Last, e, beat, (beat == 9));
         end
         beat++;
         @(posedge CLK); #1;
         cyc++;
      end
      n_cmp++; if (cyc !== 11) begin n_err++; $display("FAIL basic_frame_len: got %0d want 11", cyc); end
   endtask

   task automatic test_backpressure();
      int beat, cyc, hold;
      logic signed [9:0] e;
      for (int i = 0; i < 10; i++) xs[i] = 10'(i + 1);
      Out_ready = 1'b1;
      load_frame();
      beat = 0; cyc = 1; hold = 0;
      while (Ready !== 1'b1 && cyc < 40) begin
         Out_ready = !(beat == 4 && hold < 3);
         @(negedge CLK);
         if (Out_ready) begin
            e = (q.size() > 0) ? q.pop_front() : 10'sd0;
            n_cmp++;
            if (Valid !== 1'b1 || Outdato !== e || Index !== 4'(beat)) begin
               n_err++;
               $display("FAIL bp beat %0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                        beat, Valid, Outdato, Index, e, beat);
            end
            beat++;
         end else begin
            hold++;
            n_cmp++;
            if (Valid !== 1'b1 || Outdato !== 10'sd5 || Index !== 4'd4 || Last !== 1'b0) begin
               n_err++;
               $display("FAIL bp_hold %0d: got v=%b d=%0d i=%0d l=%b want v=1 d=5 i=4 l=0",
                        hold, Valid, Outdato, Index, Last);
            end
         end
         @(posedge CLK); #1;
         cyc++;
      end
      Out_ready = 1'b1;
      n_cmp++; if (cyc !== 14) begin n_err++; $display("FAIL bp_frame_len: got %0d want 14", cyc); end
   endtask

   task automatic test_load_busy();
      int beat, cyc;
      logic signed [9:0] e;
      for (int i = 0; i < 10; i++) xs[i] = 10'(i + 1);
      Out_ready = 1'b1;
      load_frame();
      beat = 0; cyc = 1;
      while (Ready !== 1'b1 && cyc < 40) begin
         Load = (beat == 2);
         if (beat == 2) for (int i = 0; i < 10; i++) xs[i] = 10'(100 + i);
         @(negedge CLK);
         e = (q.size() > 0) ? q.pop_front() : 10'sd0;
         n_cmp++;
         if (Valid !== 1'b1 || Outdato !== e || Index !== 4'(beat)) begin
            n_err++;
            $display("FAIL busy beat %0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                     beat, Valid, Outdato, Index, e, beat);
         end
         beat++;
         @(posedge CLK); #1;
         cyc++;
      end
      Load = 1'b0;
      n_cmp++; if (cyc !== 11) begin n_err++; $display("FAIL busy_frame_len: got %0d want 11", cyc); end
      repeat (2) begin
         @(negedge CLK);
         n_cmp++;
         if (Valid !== 1'b0 || Ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_no_second: got v=%b r=%b want v=0 r=1", Valid, Ready);
         end
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_mid();
      int beat, cyc;
      logic signed [9:0] e;
      for (int i = 0; i < 10; i++) xs[i] = 10'(i + 1);
      Out_ready = 1'b1;
      load_frame();
      beat = 0;
      while (beat < 6) begin
         @(posedge CLK); #1;
         beat++;
      end
      n_cmp++; if (Index !== 4'd6) begin n_err++; $display("FAIL rst_mid_pos: got %0d want 6", Index); end
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      q.delete();
      @(negedge CLK);
      n_cmp++;
      if (Valid !== 1'b0 || Ready !== 1'b1 || Outdato !== 10'sd0 || Index !== 4'd0 || Last !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: got v=%b r=%b d=%0d i=%0d l=%b want v=0 r=1 d=0 i=0 l=0",
                  Valid, Ready, Outdato, Index, Last);
      end
      for (int i = 0; i < 10; i++) xs[i] = 10'(20 + i);
      load_frame();
      beat = 0; cyc = 1;
      while (Ready !== 1'b1 && cyc < 40) begin
         @(negedge CLK);
         e = (q.size() > 0) ? q.pop_front() : 10'sd0;
         n_cmp++;
         if (Valid !== 1'b1 || Outdato !== e || Index !== 4'(beat)) begin
            n_err++;
            $display("FAIL rst_refill beat %0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                     beat, Valid, Outdato, Index, e, beat);
         end
         beat++;
         @(posedge CLK); #1;
         cyc++;
      end
      n_cmp++; if (cyc !== 11) begin n_err++; $display("FAIL rst_refill_len: got %0d want 11", cyc); end
   endtask

   task automatic test_sign();
      int beat, cyc;
      logic signed [9:0] e;
      for (int i = 0; i < 10; i++) xs[i] = '0;
      xs[0] = -10'sd5; xs[1] = -10'sd512; xs[2] = 10'sd511;
      Out_ready = 1'b1;
      load_frame();
      beat = 0; cyc = 1;
      while (Ready !== 1'b1 && cyc < 40) begin
         @(negedge CLK);
         e = (q.size() > 0) ? q.pop_front() : 10'sd0;
         n_cmp++;
         if (Valid !== 1'b1 || Outdato !== e) begin
            n_err++;
            $display("FAIL sign beat %0d: got v=%b d=%0d want v=1 d=%0d", beat, Valid, Outdato, e);
         end
         beat++;
         @(posedge CLK); #1;
         cyc++;
      end
      n_cmp++; if (beat !== 10) begin n_err++; $display("FAIL sign_beats: got %0d want 10", beat); end
   endtask

   task automatic test_loopback();
      int beat, cyc;
      logic signed [9:0] e;
      for (int i = 0; i < 10; i++) xs[i] = 10'($urandom);
      load_frame();
      beat = 0; cyc = 1;
      while (Ready !== 1'b1 && cyc < 200) begin
         Out_ready = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (Out_ready) begin
            e = (q.size() > 0) ? q.pop_front() : 10'sd0;
            n_cmp++;
            if (Valid !== 1'b1 || Outdato !== e || Last !== (beat == 9)) begin
               n_err++;
               $display("FAIL loop beat %0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                        beat, Valid, Outdato, Last, e, (beat == 9));
            end
            beat++;
         end
         @(posedge CLK); #1;
         cyc++;
      end
      n_cmp++; if (Ready !== 1'b1) begin n_err++; $display("FAIL loop_timeout: got r=%b want 1", Ready); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (y[i] !== model(xs[i])) begin
            n_err++;
            $display("FAIL loop_Y%0d: got %0d want %0d", i, y[i], model(xs[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_load_busy();
      test_reset_mid();
      test_sign();
      test_loopback();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
